// File: rtl/dmem_dual_port_arbiter.sv
// Serialises the two MEM-stage lanes onto one synchronous-read data memory port.
// Optional perf counters (conflict_cnt, access_cnt) are built when DMEM_ARB_PERF_CNT_EN is defined.
module dmem_dual_port_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              re2,
  input  logic              we2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata2,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
`ifdef DMEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       access_cnt
`endif
);

  typedef enum logic {StIdle, StSecond} state_e;
  typedef enum logic [1:0] {SrcNone, SrcMem, SrcHold} src_e;

  state_e            state_q, state_d;
  src_e              src1_q, src1_d, src2_q, src2_d;
  logic [DATA_W-1:0] hold1_q, hold1_d;
  logic              lane1_rd_q, lane1_rd_d;

  logic req1, req2, rd1, rd2;

  // A store wins over a load in the same lane; the read is dropped.
  assign req1 = re1 | we1;
  assign req2 = re2 | we2;
  assign rd1  = re1 & ~we1;
  assign rd2  = re2 & ~we2;

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    stall      = 1'b0;
    state_d    = state_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    hold1_d    = hold1_q;
    lane1_rd_d = lane1_rd_q;
    unique case (state_q)
      StIdle: begin
        if (req1 && req2) begin
          mem_en     = 1'b1;
          mem_we     = we1;
          mem_addr   = addr1;
          mem_wdata  = wdata1;
          stall      = 1'b1;
          state_d    = StSecond;
          lane1_rd_d = rd1;
        end else if (req1) begin
          mem_en    = 1'b1;
          mem_we    = we1;
          mem_addr  = addr1;
          mem_wdata = wdata1;
          src1_d    = rd1 ? SrcMem : SrcNone;
          src2_d    = SrcNone;
        end else if (req2) begin
          mem_en    = 1'b1;
          mem_we    = we2;
          mem_addr  = addr2;
          mem_wdata = wdata2;
          src1_d    = SrcNone;
          src2_d    = rd2 ? SrcMem : SrcNone;
        end else begin
          src1_d = SrcNone;
          src2_d = SrcNone;
        end
      end
      StSecond: begin
        // Lane 1's read data arrives now; park it while lane 2 uses the port.
        mem_en    = 1'b1;
        mem_we    = we2;
        mem_addr  = addr2;
        mem_wdata = wdata2;
        state_d   = StIdle;
        if (lane1_rd_q) hold1_d = mem_rdata;
        src1_d    = lane1_rd_q ? SrcHold : SrcNone;
        src2_d    = rd2 ? SrcMem : SrcNone;
      end
      default: state_d = StIdle;
    endcase
    // Reset abandons any in-flight access so nothing reaches memory on the reset edge.
    if (!rst) begin
      mem_en = 1'b0;
      mem_we = 1'b0;
      stall  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      src1_q     <= SrcNone;
      src2_q     <= SrcNone;
      hold1_q    <= '0;
      lane1_rd_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      hold1_q    <= hold1_d;
      lane1_rd_q <= lane1_rd_d;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    unique case (src1_q)
      SrcMem:  rdata1 = mem_rdata;
      SrcHold: rdata1 = hold1_q;
      default: rdata1 = '0;
    endcase
    if (src2_q == SrcMem) rdata2 = mem_rdata;
  end

`ifdef DMEM_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      conflict_cnt <= '0;
      access_cnt   <= '0;
    end else begin
      if (stall)  conflict_cnt <= conflict_cnt + 32'd1;
      if (mem_en) access_cnt   <= access_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_dual_port_arbiter.sv
// Randomised bench for dmem_dual_port_arbiter: a sync-read memory drives the DUT and an
// in-order reference memory (lane 1 then lane 2) predicts every load result.
module tb_dmem_dual_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        re1 = 1'b0, we1 = 1'b0, re2 = 1'b0, we2 = 1'b0;
  logic [9:0]  addr1 = '0, addr2 = '0;
  logic [31:0] wdata1 = '0, wdata2 = '0;
  logic        mem_en, mem_we, stall;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata, rdata1, rdata2;
`ifdef DMEM_ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt, access_cnt;
`endif

  logic [31:0] dmem    [0:1023];
  logic [31:0] ref_mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_dual_port_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .re1       (re1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .re2       (re2),
    .we2       (we2),
    .addr2     (addr2),
    .wdata2    (wdata2),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .stall     (stall),
    .rdata1    (rdata1),
    .rdata2    (rdata2)
`ifdef DMEM_ARB_PERF_CNT_EN
    ,
    .conflict_cnt (conflict_cnt),
    .access_cnt   (access_cnt)
`endif
  );

  // Single-port synchronous-read memory.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) dmem[mem_addr] <= mem_wdata;
      else        mem_rdata <= dmem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_word(input logic [9:0] a, input logic [31:0] v);
    dmem[a]    = v;
    ref_mem[a] = v;
  endtask

  task automatic drive(input logic r1, input logic w1, input logic [9:0] a1, input logic [31:0] d1,
                       input logic r2, input logic w2, input logic [9:0] a2, input logic [31:0] d2);
    re1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    re2 = r2; we2 = w2; addr2 = a2; wdata2 = d2;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 10'd1, 32'd0, 1'b1, 1'b0, 10'd2, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_rdata2", rdata2, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
  endtask

  // One instruction pair from MEM to WB; called and returns at posedge+1.
  task automatic run_pair(input logic r1, input logic w1, input logic [9:0] a1, input logic [31:0] d1,
                          input logic r2, input logic w2, input logic [9:0] a2, input logic [31:0] d2);
    logic q1, q2;
    logic [31:0] e1, e2;
    q1 = r1 | w1;
    q2 = r2 | w2;
    e1 = (r1 && !w1) ? ref_mem[a1] : 32'd0;
    if (w1) ref_mem[a1] = d1;
    e2 = (r2 && !w2) ? ref_mem[a2] : 32'd0;
    if (w2) ref_mem[a2] = d2;
    drive(r1, w1, a1, d1, r2, w2, a2, d2);
    @(negedge clk);
    check("stall", {31'd0, stall}, {31'd0, q1 & q2});
    check("mem_en", {31'd0, mem_en}, {31'd0, q1 | q2});
    if (q1) begin
      check("addr_l1", {22'd0, mem_addr}, {22'd0, a1});
      check("we_l1", {31'd0, mem_we}, {31'd0, w1});
      if (w1) check("wdata_l1", mem_wdata, d1);
    end else if (q2) begin
      check("addr_l2", {22'd0, mem_addr}, {22'd0, a2});
      check("we_l2", {31'd0, mem_we}, {31'd0, w2});
      if (w2) check("wdata_l2", mem_wdata, d2);
    end
    if (q1 && q2) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("second_stall", {31'd0, stall}, 32'd0);
      check("second_en", {31'd0, mem_en}, 32'd1);
      check("second_addr", {22'd0, mem_addr}, {22'd0, a2});
      check("second_we", {31'd0, mem_we}, {31'd0, w2});
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    @(negedge clk);
    check("wb_rdata1", rdata1, e1);
    check("wb_rdata2", rdata2, e2);
    check("wb_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int bad;
    logic [31:0] old60;
    for (int i = 0; i < 1024; i++) set_word(i[9:0], $urandom);
    set_word(10'h004, 32'hDEADBEEF);
    set_word(10'h010, 32'h11111111);
    set_word(10'h020, 32'h22222222);
    set_word(10'h030, 32'h00000000);
    set_word(10'h040, 32'h12345678);

    @(posedge clk); #1;
    do_reset();

    run_pair(1'b1, 1'b0, 10'h004, 32'd0, 1'b0, 1'b0, 10'h000, 32'd0);
    run_pair(1'b1, 1'b0, 10'h010, 32'd0, 1'b1, 1'b0, 10'h020, 32'd0);
    run_pair(1'b0, 1'b1, 10'h030, 32'hA5A5A5A5, 1'b1, 1'b0, 10'h030, 32'd0);
    run_pair(1'b1, 1'b0, 10'h040, 32'd0, 1'b0, 1'b1, 10'h040, 32'h0);
    run_pair(1'b1, 1'b0, 10'h040, 32'd0, 1'b0, 1'b0, 10'h000, 32'd0);
    run_pair(1'b0, 1'b1, 10'h070, 32'h1, 1'b0, 1'b1, 10'h070, 32'h2);
    run_pair(1'b0, 1'b0, 10'h000, 32'd0, 1'b1, 1'b0, 10'h070, 32'd0);

    // Reset lands on the SECOND cycle of a dual store.
    old60 = ref_mem[10'h060];
    ref_mem[10'h050] = 32'hCAFE0050;
    drive(1'b0, 1'b1, 10'h050, 32'hCAFE0050, 1'b0, 1'b1, 10'h060, 32'hCAFE0060);
    @(negedge clk);
    check("rs_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rs_mem_en", {31'd0, mem_en}, 32'd0);
    check("rs_stall0", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    @(negedge clk);
    check("rs_rdata1", rdata1, 32'd0);
    check("rs_rdata2", rdata2, 32'd0);
    check("rs_mem60", dmem[10'h060], old60);
    check("rs_mem50", dmem[10'h050], 32'hCAFE0050);
    @(posedge clk); #1;
    run_pair(1'b1, 1'b0, 10'h060, 32'd0, 1'b1, 1'b0, 10'h050, 32'd0);

    for (int n = 0; n < 300; n++) begin
      run_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
               $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               10'($urandom_range(0, 15)), $urandom);
    end

`ifdef DMEM_ARB_PERF_CNT_EN
    do_reset();
    check("cnt_reset", conflict_cnt | access_cnt, 32'd0);
    run_pair(1'b1, 1'b0, 10'h001, 32'd0, 1'b1, 1'b0, 10'h002, 32'd0);
    run_pair(1'b0, 1'b1, 10'h003, 32'h3, 1'b1, 1'b0, 10'h004, 32'd0);
    run_pair(1'b1, 1'b0, 10'h005, 32'd0, 1'b0, 1'b1, 10'h006, 32'h6);
    run_pair(1'b1, 1'b0, 10'h007, 32'd0, 1'b0, 1'b0, 10'h000, 32'd0);
    run_pair(1'b0, 1'b0, 10'h000, 32'd0, 1'b0, 1'b1, 10'h008, 32'h8);
    check("conflict_cnt", conflict_cnt, 32'd3);
    check("access_cnt", access_cnt, 32'd8);
`endif

    bad = 0;
    for (int i = 0; i < 1024; i++) if (dmem[i] !== ref_mem[i]) bad++;
    check("mem_final_mismatches", bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_dual_port_arbiter.md
Name: dmem_dual_port_arbiter

Overview:
- Shares one single-port, synchronous-read data memory between the two MEM-stage lanes of the dual-issue pipeline.
- When both lanes access memory in the same cycle, it serialises them: lane 1 goes first (older instruction), then lane 2.
- During the conflict it stalls the pipeline for one cycle and holds lane 1's read data until WB.
- When only one lane, or neither, accesses memory, it passes the request straight through with zero added latency.

Parameters:
- ADDR_W, 10, data-memory word-address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low; all state clears on the rising clk edge while rst=0.
- re1  in  1  lane 1 MEM-stage read enable (MemReadEn1_MEM).
- we1  in  1  lane 1 MEM-stage write enable (MemWriteEn1_MEM).
- addr1  in  ADDR_W  lane 1 word address (aluRes1_MEM low bits).
- wdata1  in  DATA_W  lane 1 store data (forwardBRes1_MEM).
- re2, we2, addr2, wdata2  in  1/1/ADDR_W/DATA_W  same signals for lane 2.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read is issued.
- stall  out  1  holds PC, IFID, IDEX and EXMEM; inserts no bubble into MEM/WB.
- rdata1  out  DATA_W  lane 1 load result, valid in lane 1's WB cycle.
- rdata2  out  DATA_W  lane 2 load result, valid in lane 2's WB cycle.

Behaviour:
- Definitions: req1 = re1|we1; req2 = re2|we2. re and we of the same lane are never both 1; if they are, we wins and the read is dropped.
- FSM states: IDLE, SECOND. Reset state is IDLE.
- IDLE, req1 & req2:
  - Issue lane 1: mem_en=1, mem_we=we1, mem_addr=addr1, mem_wdata=wdata1.
  - stall=1; next state SECOND.
- IDLE, exactly one of req1/req2: issue that lane; stall=0; stay in IDLE.
- IDLE, neither: mem_en=0, stall=0.
- SECOND (MEM inputs are held stable by the stall):
  - Issue lane 2; stall=0; next state IDLE.
  - Capture mem_rdata (lane 1's read result) into hold1 when lane 1 was a read.
- Read-data steering uses registered tags src1/src2 ∈ {MEM, HOLD, NONE}, updated whenever stall=0:
  - After a conflict: rdata1 = hold1, rdata2 = mem_rdata.
  - Lane 1 alone: rdata1 = mem_rdata.
  - Lane 2 alone: rdata2 = mem_rdata.
  - A lane that did not read outputs 0.
- Ordering: lane 1 is always issued before lane 2.
  - Lane 1 store + lane 2 load to the same address: the load returns the new data.
  - Lane 1 load + lane 2 store to the same address: the load returns the old data.
  - Both lanes store to the same address: lane 2's value persists.
- stall is combinational from IDLE & req1 & req2. Maximum one stall cycle per instruction pair.
- Reset values:
  - state=IDLE; hold1=0; src tags=NONE.
  - stall=0, mem_en=0, mem_we=0, rdata1=0, rdata2=0.
  - Reset asserted while in SECOND: lane 2's access is abandoned and does not reach memory on that edge.
- Interaction with the load-use hazard: while stall=1, the IDEX flush and hold logic of the pipeline is gated by stall, so no instruction is lost.

Optional Feature:
- Macro: DMEM_ARB_PERF_CNT_EN.
- When defined:
  - Adds outputs conflict_cnt [31:0] and access_cnt [31:0].
  - conflict_cnt increments on every IDLE→SECOND transition.
  - access_cnt increments on every cycle with mem_en=1.
  - Both counters wrap at 2^32−1→0 and reset to 0 on rst=0.
- When undefined: the ports and counters are absent; arbitration behaviour is identical.

Test Plan:
- Lane 1 only: re1=1, addr1=0x004, memory[4]=0xDEADBEEF → mem_addr=0x004 in the same cycle, stall=0, rdata1=0xDEADBEEF next cycle, rdata2=0.
- Dual load: re1=re2=1, addr1=0x010 (=0x11111111), addr2=0x020 (=0x22222222) → stall=1 for exactly 1 cycle; memory sees 0x010 then 0x020; in WB rdata1=0x11111111 and rdata2=0x22222222 in the same cycle.
- Store then load, same address: we1=1, addr1=0x030, wdata1=0xA5A5A5A5; re2=1, addr2=0x030 (old value 0) → rdata2=0xA5A5A5A5; 1 stall cycle.
- Load then store, same address: re1=1, addr1=0x040 (=0x12345678); we2=1, addr2=0x040, wdata2=0x0 → rdata1=0x12345678; memory[0x40]=0 afterwards.
- Reset in SECOND: dual store to 0x050/0x060, rst=0 asserted on the SECOND cycle → state=IDLE, stall=0, memory[0x060] unchanged, rdata outputs 0.
- DMEM_ARB_PERF_CNT_EN defined: 3 dual accesses + 2 single accesses → conflict_cnt=3, access_cnt=8.
